// File: rtl/gravity_pkg.sv
// gravity_pkg
// Shared types and constants for the gravity drop scheduler.
//   state_t       : handshake FSM encoding (IDLE / REQ / GAP)
//   RATE_*        : rate-divider digitControl codes
//   level_to_rate : difficulty level -> rate-select code (faster level, shorter period)
package gravity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] RATE_0P5S = 2'b00;
    localparam logic [1:0] RATE_1S   = 2'b01;
    localparam logic [1:0] RATE_2S   = 2'b10;
    localparam logic [1:0] RATE_4S   = 2'b11;

    // level 0 is slowest (4 s), level 3 fastest (0.5 s): rate = 3 - level
    function automatic logic [1:0] level_to_rate(input logic [1:0] lvl);
        logic [1:0] r;
        case (lvl)
            2'd0:    r = RATE_4S;
            2'd1:    r = RATE_2S;
            2'd2:    r = RATE_1S;
            default: r = RATE_0P5S;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gravity_drop_scheduler_pending_counter.sv
// pending_counter
// Saturating up/down counter of buffered gravity drops.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : add 1
//   i_inc2         : add 2 (takes precedence over i_inc)
//   i_dec          : subtract 1 (never goes below 0)
//   i_clr          : synchronous clear, overrides everything
//   o_count        : current count
//   o_sat          : this cycle's net change would exceed MAX_PENDING and was clipped
module pending_counter
    import gravity_pkg::*;
#(
    parameter int MAX_PENDING = 15,
    parameter int PEND_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc,
    input  logic              i_inc2,
    input  logic              i_dec,
    input  logic              i_clr,
    output logic [PEND_W-1:0] o_count,
    output logic              o_sat
);

    // two guard bits so count + 2 never wraps before the saturation compare
    localparam int SW = PEND_W + 2;

    logic [PEND_W-1:0] r_count;
    logic [SW-1:0]     w_add;
    logic [SW-1:0]     w_sum;
    logic [SW-1:0]     w_net;
    logic              w_over;
    logic [PEND_W-1:0] w_next;

    always_comb begin
        w_add = '0;
        if (i_inc2)     w_add = SW'(2);
        else if (i_inc) w_add = SW'(1);
        w_sum = {2'b00, r_count} + w_add;
        // increment and decrement are netted first, so a tick and an ack
        // together at saturation hold the count without flagging overflow
        w_net = w_sum;
        if (i_dec && (w_sum != '0)) w_net = w_sum - SW'(1);
        w_over = (w_net > SW'(MAX_PENDING));
        if (i_clr)       w_next = '0;
        else if (w_over) w_next = PEND_W'(MAX_PENDING);
        else             w_next = w_net[PEND_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_count <= '0;
        else          r_count <= w_next;
    end

    assign o_count = r_count;
    assign o_sat   = w_over & ~i_clr;

endmodule

// File: rtl/gravity_drop_scheduler.sv
// gravity_drop_scheduler
// Buffers rate-divider ticks as pending gravity drops and offers them one at
// a time to the game FSM over a req/ack handshake; drives the divider's
// rate-select and enable from level / soft_drop / enable.
// Optional feature macro: GRAVITY_SOFT_DROP_EN (soft_drop forces 0.5 s rate
// and makes each accepted tick worth two drops). Undefined: soft_drop ignored.
//   clock50M, clear_b : 50 MHz clock, async active-low reset
//   tick, enable      : divider pulse, gravity enable
//   level, soft_drop  : difficulty, soft-drop button
//   flush             : discard all pending drops (piece lock / spawn)
//   drop_ack          : game FSM accepts the offered drop
//   drop_req          : drop offered
//   rate_sel, rate_en : to divider digitControl / enable
//   pending           : buffered drops including the one offered
//   overflow          : sticky, a tick was lost to saturation
module gravity_drop_scheduler
    import gravity_pkg::*;
#(
    parameter int MAX_PENDING = 15,
    parameter int PEND_W      = 4
) (
    input  logic              clock50M,
    input  logic              clear_b,
    input  logic              tick,
    input  logic              enable,
    input  logic [1:0]        level,
    input  logic              soft_drop,
    input  logic              flush,
    input  logic              drop_ack,
    output logic              drop_req,
    output logic [1:0]        rate_sel,
    output logic              rate_en,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rate_sel;
    logic              r_rate_en;
    logic              r_overflow;
    logic [PEND_W-1:0] w_count;
    logic              w_sat;
    logic              w_tick_acc;
    logic              w_ack_vld;
    logic              w_inc;
    logic              w_inc2;
    logic [1:0]        w_rate_nxt;

    assign w_tick_acc = tick & enable;
    // acks outside REQ are stray and must not consume a drop
    assign w_ack_vld  = drop_ack & (r_state == REQ);

`ifdef GRAVITY_SOFT_DROP_EN
    assign w_inc      = w_tick_acc & ~soft_drop;
    assign w_inc2     = w_tick_acc & soft_drop;
    assign w_rate_nxt = soft_drop ? RATE_0P5S : level_to_rate(level);
`else
    logic w_unused_soft_drop;
    assign w_unused_soft_drop = soft_drop;
    assign w_inc      = w_tick_acc;
    assign w_inc2     = 1'b0;
    assign w_rate_nxt = level_to_rate(level);
`endif

    pending_counter #(
        .MAX_PENDING (MAX_PENDING),
        .PEND_W      (PEND_W)
    ) u_pending_counter (
        .i_clk   (clock50M),
        .i_rst_n (clear_b),
        .i_inc   (w_inc),
        .i_inc2  (w_inc2),
        .i_dec   (w_ack_vld),
        .i_clr   (flush),
        .o_count (w_count),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clock50M or negedge clear_b) begin
        if (!clear_b) begin
            r_state    <= IDLE;
            r_rate_sel <= RATE_4S;
            r_rate_en  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate_sel <= w_rate_nxt;
            r_rate_en  <= enable;
            if (flush)      r_overflow <= 1'b0;
            else if (w_sat) r_overflow <= 1'b1;
        end
    end

    // decisions use the registered count, so a tick in IDLE shows up as
    // drop_req one edge after it lands in pending
    always_comb begin
        w_state_nxt = r_state;
        drop_req    = 1'b0;
        case (r_state)
            IDLE: if (w_count != '0) w_state_nxt = REQ;
            REQ: begin
                drop_req = 1'b1;
                if (w_ack_vld) w_state_nxt = GAP;
            end
            GAP:     w_state_nxt = (w_count != '0) ? REQ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    assign pending  = w_count;
    assign overflow = r_overflow;
    assign rate_sel = r_rate_sel;
    assign rate_en  = r_rate_en;

endmodule

// File: tb/tb_gravity_drop_scheduler.sv
module tb_gravity_drop_scheduler;

    logic       clk = 1'b0;
    logic       clear_b, tick, enable, soft_drop, flush, drop_ack;
    logic [1:0] level;
    logic       drop_req, rate_en, overflow;
    logic [1:0] rate_sel;
    logic [3:0] pending;

    gravity_drop_scheduler #(.MAX_PENDING(15), .PEND_W(4)) dut (
        .clock50M (clk),
        .clear_b  (clear_b),
        .tick     (tick),
        .enable   (enable),
        .level    (level),
        .soft_drop(soft_drop),
        .flush    (flush),
        .drop_ack (drop_ack),
        .drop_req (drop_req),
        .rate_sel (rate_sel),
        .rate_en  (rate_en),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // mask bits: 0 pending, 1 drop_req, 2 overflow, 3 rate_sel, 4 rate_en
    localparam logic [4:0] M_P = 5'b00001, M_R = 5'b00010, M_O = 5'b00100,
                           M_S = 5'b01000, M_E = 5'b10000;

    typedef struct {
        int         cyc;
        string      nm;
        logic [4:0] m;
        logic [3:0] p;
        logic       r;
        logic       o;
        logic [1:0] rs;
        logic       re;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef GRAVITY_SOFT_DROP_EN
    localparam int SOFT_INC = 2;
    localparam logic [1:0] SOFT_RS = 2'b00;
`else
    localparam int SOFT_INC = 1;
    localparam logic [1:0] SOFT_RS = 2'b11;
`endif

    always @(posedge clk) cycle++;

    task automatic cmp(input string nm, input string f, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s.%s cyc=%0d got=%0d expected=%0d", nm, f, cycle, got, want);
        end
    endtask

    // monitor: every negedge, retire the expectations due this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cycle) cmp(e.nm, "late", cycle, e.cyc);
            if (e.m[0]) cmp(e.nm, "pending",  int'(pending),  int'(e.p));
            if (e.m[1]) cmp(e.nm, "drop_req", int'(drop_req), int'(e.r));
            if (e.m[2]) cmp(e.nm, "overflow", int'(overflow), int'(e.o));
            if (e.m[3]) cmp(e.nm, "rate_sel", int'(rate_sel), int'(e.rs));
            if (e.m[4]) cmp(e.nm, "rate_en",  int'(rate_en),  int'(e.re));
        end
    end

    // expectation for the edge just taken, checked at the coming negedge
    task automatic expect_now(input string nm, input logic [4:0] m, input int p,
                              input logic r, input logic o, input logic [1:0] rs,
                              input logic re);
        exp_t e;
        e.cyc = cycle; e.nm = nm; e.m = m; e.p = p[3:0];
        e.r = r; e.o = o; e.rs = rs; e.re = re;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1; cyc(); flush = 1'b0;
        expect_now("flush", M_P | M_R | M_O, 0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        clear_b = 1'b0; tick = 0; enable = 0; soft_drop = 0; flush = 0;
        drop_ack = 0; level = 2'd0;

        // reset values
        cyc();
        expect_now("reset", 5'b11111, 0, 1'b0, 1'b0, 2'b11, 1'b0);
        cyc();
        clear_b = 1'b1; enable = 1'b1;
        cyc();
        expect_now("en_on", M_E | M_S, 0, 1'b0, 1'b0, 2'b11, 1'b1);

        // single tick -> req one edge later -> ack
        tick = 1; cyc(); tick = 0;
        expect_now("t1_tick", M_P | M_R, 1, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("t1_req", M_P | M_R, 1, 1'b1, 1'b0, 2'b00, 1'b0);
        drop_ack = 1; cyc(); drop_ack = 0;
        expect_now("t1_ack", M_P | M_R, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("t1_idle", M_P | M_R, 0, 1'b0, 1'b0, 2'b00, 1'b0);

        // 20 ticks with no ack -> saturation and sticky overflow
        for (int k = 1; k <= 20; k++) begin
            tick = 1; cyc();
            expect_now("sat", M_P | M_R | M_O, (k > 15) ? 15 : k, (k >= 2), (k >= 16),
                       2'b00, 1'b0);
        end
        tick = 0;
        do_flush();
        cyc();
        expect_now("post_flush", M_P | M_R | M_O, 0, 1'b0, 1'b0, 2'b00, 1'b0);

        // build pending=3, then tick+ack together
        for (int k = 1; k <= 3; k++) begin
            tick = 1; cyc();
            expect_now("build3", M_P | M_R, k, (k >= 2), 1'b0, 2'b00, 1'b0);
        end
        drop_ack = 1; cyc(); tick = 0; drop_ack = 0;
        expect_now("tick_ack_gap", M_P | M_R, 3, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("tick_ack_req", M_P | M_R, 3, 1'b1, 1'b0, 2'b00, 1'b0);
        do_flush();

        // level -> rate_sel
        for (int l = 0; l < 4; l++) begin
            logic [1:0] lv;
            lv = 2'(l);
            level = lv; cyc();
            expect_now("level", M_S, 0, 1'b0, 1'b0, 2'(3 - l), 1'b0);
        end
        level = 2'd0; soft_drop = 1; cyc();
        expect_now("soft_rs", M_S, 0, 1'b0, 1'b0, SOFT_RS, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick = 1; cyc();
            expect_now("soft_tick", M_P | M_O, (k * SOFT_INC > 15) ? 15 : k * SOFT_INC,
                       1'b0, (k * SOFT_INC > 15), 2'b00, 1'b0);
        end
        tick = 0; soft_drop = 0;
        do_flush();
        level = 2'd3;

        // enable low: ticks ignored, pending still delivered
        for (int k = 1; k <= 2; k++) begin
            tick = 1; cyc();
        end
        tick = 0; enable = 0; cyc();
        expect_now("dis", M_P | M_R | M_E | M_S, 2, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick = 1; cyc();
            expect_now("dis_tick", M_P | M_R | M_E, 2, 1'b1, 1'b0, 2'b00, 1'b0);
        end
        tick = 0;
        drop_ack = 1; cyc(); drop_ack = 0;
        expect_now("dis_ack1", M_P | M_R, 1, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("dis_req2", M_P | M_R, 1, 1'b1, 1'b0, 2'b00, 1'b0);
        drop_ack = 1; cyc(); drop_ack = 0;
        expect_now("dis_ack2", M_P | M_R, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("dis_idle", M_P | M_R, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        enable = 1;

        // async reset mid-handshake
        for (int k = 1; k <= 4; k++) begin
            tick = 1; cyc();
        end
        tick = 0;
        expect_now("pre_rst", M_P | M_R, 4, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk); #1;
        cyc();
        #1 clear_b = 1'b0;
        expect_now("async_rst", 5'b11111, 0, 1'b0, 1'b0, 2'b11, 1'b0);
        @(negedge clk); #1;
        clear_b = 1'b1; drop_ack = 1;
        cyc(); drop_ack = 0;
        expect_now("ack_ignored", M_P | M_R | M_O, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        expect_now("rst_idle", M_P | M_R, 0, 1'b0, 1'b0, 2'b00, 1'b0);

        // drain the scoreboard, bounded
        for (int k = 0; k < 10 && q.size() > 0; k++) cyc();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "unchecked", 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gravity_drop_scheduler.md
# gravity_drop_scheduler

Consumer end of the rate-divider tick interface. Accepts the one-cycle tick pulses produced by the 50 MHz rate divider, buffers them as pending gravity drops, and presents them one at a time to the game-control FSM over a req/ack handshake. It also drives the divider's 2-bit rate-select input from the current level and the soft-drop button, closing the loop between game logic and gravity timing.

## Interface
- MAX_PENDING, 15: saturation limit of the pending-drop counter, 1..15.
- PEND_W, 4: width of the pending count; must hold MAX_PENDING.
- clock50M  in  1  system clock, 50 MHz, all logic on rising edge.
- clear_b  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle pulse from the rate divider (high when its count is 0).
- enable  in  1  gravity enable; when low, ticks are ignored and rate_en is low.
- level  in  2  difficulty: 0 slowest .. 3 fastest.
- soft_drop  in  1  player soft-drop button, synchronised upstream.
- flush  in  1  one-cycle pulse on piece lock or spawn; discards all pending drops.
- drop_ack  in  1  one-cycle pulse from game FSM accepting the current drop.
- drop_req  out  1  a drop is offered; held until acknowledged.
- rate_sel  out  2  to divider digitControl: 00 = 0.5 s, 01 = 1 s, 10 = 2 s, 11 = 4 s.
- rate_en  out  1  to divider enable.
- pending  out  PEND_W  buffered drops not yet acknowledged, including the one offered.
- overflow  out  1  sticky: a tick arrived while pending == MAX_PENDING.

## Operation
- Reset values: drop_req 0, pending 0, overflow 0, rate_sel 11, rate_en 0, state IDLE.
- rate_sel = 3 - level; with soft_drop high, rate_sel = 00. Registered, updates one cycle after input change.
- rate_en = enable, registered.
- Accepted tick: tick & enable. Increments pending, saturating at MAX_PENDING. A tick at saturation sets overflow. overflow clears only on reset or flush.
- Valid ack: drop_ack while drop_req is high. Decrements pending. drop_ack while drop_req is low is ignored.
- Same-cycle accepted tick and valid ack: pending unchanged, and drop_req follows the FSM.
- flush has priority over everything: pending <= 0, overflow <= 0, state <= IDLE, and any same-cycle tick or ack is discarded.
- FSM states:
  - IDLE: drop_req 0. Moves to REQ when pending > 0.
  - REQ: drop_req 1. On a valid ack, moves to GAP.
  - GAP: drop_req 0 for exactly one cycle. Then moves to REQ if pending > 0, otherwise to IDLE.
- enable low does not clear pending; buffered drops are still offered.

## Timing
- The tick is registered into pending on the same edge. drop_req rises on the following edge: 2 cycles from a tick in IDLE.
- The ack edge lowers drop_req (state GAP). Minimum req-to-req spacing is 2 cycles (REQ, then GAP, then REQ).
- pending, drop_req, overflow and rate_sel are all registered outputs; there are no combinational paths from input to output.
- Asserting clear_b mid-handshake drops the request immediately (asynchronous reset). The game FSM must treat this as no drop.

## Configuration
- GRAVITY_SOFT_DROP_EN
  - Defined: soft_drop forces rate_sel = 00, and every accepted tick while soft_drop is high adds 2 to pending (still saturating; overflow is set if the increment exceeds MAX_PENDING).
  - Undefined: the soft_drop port exists but is ignored; rate_sel = 3 - level only, and the increment is always 1.

## Structure
- Shared package gravity_pkg:
  - state encoding typedef (IDLE/REQ/GAP, 2 bits);
  - rate_sel constants RATE_0P5S, RATE_1S, RATE_2S, RATE_4S;
  - level-to-rate mapping function.
- One sub-module, pending_counter: a saturating up/down counter with inc, inc2, dec, clr inputs and a sat flag. The FSM and the rate-select logic stay in the top module.

## Test plan
- Reset, then one tick with enable=1 → pending=1 after the edge, drop_req=1 one cycle later. Ack → drop_req=0, pending=0; the FSM stays in IDLE.
- 20 ticks with no ack, MAX_PENDING=15 → pending saturates at 15 and overflow=1. A flush → pending=0, overflow=0, drop_req=0 next cycle.
- Tick and ack in the same cycle with pending=3 → pending stays 3. drop_req goes low for one GAP cycle, then high again.
- level=0..3 with soft_drop=0 → rate_sel 11, 10, 01, 00. With soft_drop=1 (macro defined) → rate_sel=00 and each tick adds 2. With the macro undefined → soft_drop has no effect.
- enable=0 with 5 ticks → pending unchanged and rate_en=0. Existing pending=2 is still delivered over two handshakes.
- clear_b pulsed low while drop_req=1 and pending=4 → all outputs return to reset values asynchronously; a drop_ack after release is ignored.
